// File: rtl/ds_pkg.sv
// Shared definitions for the DS lane codec: line bit order, encoder/decoder reset state
// and single-bit data/strobe encode and event-detect helpers.
package ds_pkg;

   localparam bit   LSB_FIRST   = 1'b1;
   localparam logic ENC_P_RESET = 1'b0;
   localparam logic RX_X_RESET  = 1'b0;

   // Slice position of the i-th bit on the line.
   function automatic int unsigned line_pos(input int unsigned i, input int unsigned width);
      return LSB_FIRST ? i : width - 1 - i;
   endfunction

   function automatic logic ds_strobe(input logic d, input logic p);
      return d ^ p;
   endfunction

   // A bit event is a change of d^s with respect to the previous sample.
   function automatic logic ds_event(input logic d, input logic s, input logic x_prev);
      return (d ^ s) != x_prev;
   endfunction

endpackage

// File: rtl/ds_lane_codec_if.sv
// Word handshake and parallel D/S slice bus between a DS lane codec and its user.
interface ds_lane_codec_if #(
   parameter int unsigned WIDTH = 8
);
   logic             tx_en;
   logic [WIDTH-1:0] tx_word;
   logic             tx_valid;
   logic             tx_ready;
   logic [WIDTH-1:0] tx_d_par;
   logic [WIDTH-1:0] tx_s_par;
   logic             tx_underrun;
   logic [WIDTH-1:0] rx_d_par;
   logic [WIDTH-1:0] rx_s_par;
   logic             rx_align;
   logic [WIDTH-1:0] rx_word;
   logic             rx_valid;
   logic             rx_disconnect;

   modport master (
      output tx_en, tx_word, tx_valid, rx_d_par, rx_s_par, rx_align,
      input  tx_ready, tx_d_par, tx_s_par, tx_underrun, rx_word, rx_valid, rx_disconnect
   );

   modport slave (
      input  tx_en, tx_word, tx_valid, rx_d_par, rx_s_par, rx_align,
      output tx_ready, tx_d_par, tx_s_par, tx_underrun, rx_word, rx_valid, rx_disconnect
   );
endinterface

// File: rtl/ds_word_fifo.sv
// Synchronous word FIFO with full/empty flags; a push into a full FIFO is dropped.
module ds_word_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW + 1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         if (do_push && !do_pop)      count_q <= count_q + (AW + 1)'(1);
         else if (do_pop && !do_push) count_q <= count_q - (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/ds_lane_codec.sv
// DS lane codec: FIFO-fed data/strobe slice encoder with running strobe state, and an
// edge-detecting decoder that re-packs recovered bits into words and flags disconnect.
module ds_lane_codec
   import ds_pkg::*;
#(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      FIFO_DEPTH  = 4,
   parameter logic [WIDTH-1:0] IDLE_WORD   = '0,
   parameter int unsigned      DISC_CYCLES = 64
) (
   input logic            clk,
   input logic            rst,
   ds_lane_codec_if.slave bus
);
   localparam int unsigned     CW        = $clog2(2 * WIDTH);
   localparam int unsigned     DW        = $clog2(DISC_CYCLES + 1);
   localparam logic [CW-1:0]   WORD_BITS = CW'(WIDTH);
   localparam logic [DW-1:0]   DISC_MAX  = DW'(DISC_CYCLES);

   // ---------------- TX ----------------
   logic             fifo_full, fifo_empty, fifo_pop;
   logic [WIDTH-1:0] fifo_rdata, tx_src;
   logic [WIDTH-1:0] tx_d_q, tx_d_d, tx_s_q, tx_s_d;
   logic             p_q, p_d, underrun_q;

   assign fifo_pop = bus.tx_en && !fifo_empty;

   ds_word_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.tx_valid),
      .wdata (bus.tx_word),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      tx_src = fifo_empty ? IDLE_WORD : fifo_rdata;
      tx_d_d = '0;
      tx_s_d = '0;
      p_d    = p_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         p_d = ~p_d;
         tx_d_d[line_pos(i, WIDTH)] = tx_src[i];
         tx_s_d[line_pos(i, WIDTH)] = ds_strobe(tx_src[i], p_d);
      end
   end

   // Disabling the lane also returns the encoder to its idle line state.
   always_ff @(posedge clk) begin
      if (rst || !bus.tx_en) begin
         p_q        <= ENC_P_RESET;
         tx_d_q     <= '0;
         tx_s_q     <= '0;
         underrun_q <= 1'b0;
      end else begin
         p_q        <= p_d;
         tx_d_q     <= tx_d_d;
         tx_s_q     <= tx_s_d;
         underrun_q <= fifo_empty;
      end
   end

   assign bus.tx_ready    = !fifo_full;
   assign bus.tx_d_par    = tx_d_q;
   assign bus.tx_s_par    = tx_s_q;
   assign bus.tx_underrun = underrun_q;

   // ---------------- RX ----------------
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               x_q, x_d, any_ev, d_bit, s_bit;
   logic [WIDTH-1:0]   word_q, word_d;
   logic               valid_q, valid_d;
   logic [DW-1:0]      disc_q;

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = bus.rx_align ? '0 : cnt_q;
      x_d     = x_q;
      any_ev  = 1'b0;
      word_d  = word_q;
      valid_d = 1'b0;
      d_bit   = 1'b0;
      s_bit   = 1'b0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
         d_bit = bus.rx_d_par[line_pos(j, WIDTH)];
         s_bit = bus.rx_s_par[line_pos(j, WIDTH)];
         if (ds_event(d_bit, s_bit, x_d)) begin
            acc_d[cnt_d] = d_bit;
            cnt_d        = cnt_d + CW'(1);
            any_ev       = 1'b1;
         end
         x_d = d_bit ^ s_bit;
      end
      if (cnt_d >= WORD_BITS) begin
         word_d  = acc_d[WIDTH-1:0];
         valid_d = 1'b1;
         acc_d   = acc_d >> WIDTH;
         cnt_d   = cnt_d - WORD_BITS;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         x_q     <= RX_X_RESET;
         word_q  <= '0;
         valid_q <= 1'b0;
         disc_q  <= '0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         if (any_ev)                disc_q <= '0;
         else if (disc_q != DISC_MAX) disc_q <= disc_q + DW'(1);
      end
   end

   assign bus.rx_word       = word_q;
   assign bus.rx_valid      = valid_q;
   assign bus.rx_disconnect = (disc_q >= DISC_MAX);

endmodule

// File: tb/tb_ds_lane_codec.sv
// Bench for ds_lane_codec: fixed vectors and hand sequences plus randomized traffic,
// all checked every cycle against a bit-stream/queue reference model.
module tb_ds_lane_codec;
   localparam int         W     = 8;
   localparam int         DEPTH = 4;
   localparam int         DISC  = 16;
   localparam logic [7:0] IDLE  = 8'h00;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ds_lane_codec_if #(.WIDTH(W)) bus ();

   ds_lane_codec #(
      .WIDTH       (W),
      .FIFO_DEPTH  (DEPTH),
      .IDLE_WORD   (IDLE),
      .DISC_CYCLES (DISC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [7:0] txq[$];
   logic       bitq[$];
   logic       m_dl, m_sl, m_xprev;
   int         m_idle;
   logic [7:0] e_d, e_s, e_word;
   logic       e_ur, e_valid, e_ready, e_disc;
   bit         loopback = 0;
   bit         collect = 0;
   logic [7:0] got[$];

   typedef struct {
      logic [7:0] word;
      logic [7:0] d;
      logic [7:0] s;
      logic       ur;
   } tx_vec_t;
   tx_vec_t tv[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic model_step();
      logic [7:0] w;
      int         pre;
      logic       x, ev;
      if (rst) begin
         txq.delete();
         bitq.delete();
         m_dl = 0; m_sl = 0; m_xprev = 0; m_idle = 0;
         e_d = 0; e_s = 0; e_ur = 0; e_valid = 0; e_word = 0;
      end else begin
         pre = txq.size();
         if (bus.tx_en) begin
            if (pre != 0) begin
               w = txq.pop_front();
               e_ur = 0;
            end else begin
               w = IDLE;
               e_ur = 1;
            end
            // Strobe toggles exactly when the data bit repeats.
            for (int i = 0; i < W; i++) begin
               e_d[i] = w[i];
               e_s[i] = (w[i] == m_dl) ? ~m_sl : m_sl;
               m_dl   = w[i];
               m_sl   = e_s[i];
            end
         end else begin
            e_d = 0; e_s = 0; e_ur = 0; m_dl = 0; m_sl = 0;
         end
         if (bus.tx_valid && pre < DEPTH) txq.push_back(bus.tx_word);
         if (bus.rx_align) bitq.delete();
         ev = 0;
         for (int j = 0; j < W; j++) begin
            x = bus.rx_d_par[j] ^ bus.rx_s_par[j];
            if (x != m_xprev) begin
               bitq.push_back(bus.rx_d_par[j]);
               ev = 1;
            end
            m_xprev = x;
         end
         e_valid = 0;
         if (bitq.size() >= W) begin
            for (int k = 0; k < W; k++) e_word[k] = bitq.pop_front();
            e_valid = 1;
         end
         m_idle = ev ? 0 : m_idle + 1;
      end
      e_ready = (txq.size() < DEPTH);
      e_disc  = (m_idle >= DISC);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("tx_ready", 32'(bus.tx_ready), 32'(e_ready));
      chk("tx_d_par", 32'(bus.tx_d_par), 32'(e_d));
      chk("tx_s_par", 32'(bus.tx_s_par), 32'(e_s));
      chk("tx_underrun", 32'(bus.tx_underrun), 32'(e_ur));
      chk("rx_valid", 32'(bus.rx_valid), 32'(e_valid));
      chk("rx_disconnect", 32'(bus.rx_disconnect), 32'(e_disc));
      if (e_valid) chk("rx_word", 32'(bus.rx_word), 32'(e_word));
      if (collect && bus.rx_valid && bus.rx_word != IDLE) got.push_back(bus.rx_word);
      if (loopback) begin
         bus.rx_d_par = bus.tx_d_par;
         bus.rx_s_par = bus.tx_s_par;
      end
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
      rst = 0;
   endtask

   initial begin
      logic [15:0] stream;
      logic [31:0] sd, ss;
      logic        od, os, nd;
      logic [7:0]  exp_lb[3];

      tv[0] = '{word: 8'h00, d: 8'h00, s: 8'h55, ur: 1'b0};
      tv[1] = '{word: 8'h00, d: 8'h00, s: 8'h55, ur: 1'b0};
      tv[2] = '{word: 8'hFF, d: 8'hFF, s: 8'hAA, ur: 1'b0};
      tv[3] = '{word: 8'h0F, d: 8'h0F, s: 8'h5A, ur: 1'b0};
      tv[4] = '{word: 8'h00, d: 8'h00, s: 8'h55, ur: 1'b1};
      tv[5] = '{word: 8'h00, d: 8'h00, s: 8'h55, ur: 1'b1};

      bus.tx_en = 0; bus.tx_word = 0; bus.tx_valid = 0;
      bus.rx_d_par = 0; bus.rx_s_par = 0; bus.rx_align = 0;
      rst = 1;
      tick();
      tick();
      rst = 0;
      chk("reset tx_ready", 32'(bus.tx_ready), 32'd1);
      chk("reset tx_underrun", 32'(bus.tx_underrun), 32'd0);
      chk("reset rx_word", 32'(bus.rx_word), 32'd0);
      chk("reset rx_valid", 32'(bus.rx_valid), 32'd0);
      chk("reset rx_disconnect", 32'(bus.rx_disconnect), 32'd0);

      // FIFO fill with the lane disabled, then drain through the encoder
      for (int i = 0; i < DEPTH; i++) begin
         bus.tx_valid = 1;
         bus.tx_word  = tv[i].word;
         tick();
      end
      chk("fifo full tx_ready", 32'(bus.tx_ready), 32'd0);
      bus.tx_word = 8'h77;
      tick();
      bus.tx_valid = 0;
      bus.tx_en    = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("vec%0d tx_d", i), 32'(bus.tx_d_par), 32'(tv[i].d));
         chk($sformatf("vec%0d tx_s", i), 32'(bus.tx_s_par), 32'(tv[i].s));
         chk($sformatf("vec%0d underrun", i), 32'(bus.tx_underrun), 32'(tv[i].ur));
      end

      // Loopback of TX slices into RX
      bus.tx_en = 0;
      do_reset();
      exp_lb[0] = 8'h3C; exp_lb[1] = 8'hA5; exp_lb[2] = 8'h01;
      loopback = 1; collect = 1; bus.tx_en = 1;
      for (int i = 0; i < 3; i++) begin
         bus.tx_valid = 1;
         bus.tx_word  = exp_lb[i];
         tick();
      end
      bus.tx_valid = 0;
      for (int i = 0; i < 10; i++) tick();
      loopback = 0; collect = 0;
      chk("loopback count", 32'(got.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         if (i < got.size()) chk($sformatf("loopback word%0d", i), 32'(got[i]), 32'(exp_lb[i]));

      // 2x oversampled RX stream of 0xC3 then 0x5A
      bus.tx_en = 0;
      bus.rx_d_par = 0; bus.rx_s_par = 0;
      do_reset();
      stream = 16'h5AC3;
      od = 0; os = 0;
      for (int b = 0; b < 16; b++) begin
         nd = stream[b];
         os = (nd == od) ? ~os : os;
         od = nd;
         sd[2*b] = od; sd[2*b+1] = od;
         ss[2*b] = os; ss[2*b+1] = os;
      end
      for (int k = 0; k < 4; k++) begin
         bus.rx_d_par = sd[8*k +: 8];
         bus.rx_s_par = ss[8*k +: 8];
         tick();
         chk($sformatf("os slice%0d valid", k), 32'(bus.rx_valid), 32'(k % 2));
         if (k == 1) chk("os word0", 32'(bus.rx_word), 32'h0000_00C3);
         if (k == 3) chk("os word1", 32'(bus.rx_word), 32'h0000_005A);
      end

      // Disconnect on a frozen line, cleared by one strobe toggle
      bus.rx_d_par = {W{od}};
      bus.rx_s_par = {W{os}};
      for (int i = 1; i <= DISC; i++) begin
         tick();
         if (i == DISC - 1) chk("disc before limit", 32'(bus.rx_disconnect), 32'd0);
      end
      chk("disc at limit", 32'(bus.rx_disconnect), 32'd1);
      bus.rx_s_par = {W{~os}};
      tick();
      chk("disc cleared", 32'(bus.rx_disconnect), 32'd0);

      // Align drops three pending bits
      do_reset();
      bus.rx_d_par = 8'h00; bus.rx_s_par = 8'hA0;
      tick();
      bus.rx_d_par = 8'hA7; bus.rx_s_par = 8'h0D; bus.rx_align = 1;
      tick();
      bus.rx_align = 0;
      chk("align valid", 32'(bus.rx_valid), 32'd1);
      chk("align word", 32'(bus.rx_word), 32'h0000_00A7);

      // Reset mid-word with TX active
      bus.tx_en = 1; bus.tx_valid = 1; bus.tx_word = 8'hE1;
      bus.rx_d_par = 8'h00; bus.rx_s_par = 8'h5F;
      tick();
      bus.tx_valid = 0;
      rst = 1;
      tick();
      rst = 0;
      chk("rst tx_ready", 32'(bus.tx_ready), 32'd1);
      chk("rst tx_d", 32'(bus.tx_d_par), 32'd0);
      chk("rst tx_s", 32'(bus.tx_s_par), 32'd0);
      chk("rst underrun", 32'(bus.tx_underrun), 32'd0);
      chk("rst rx_word", 32'(bus.rx_word), 32'd0);
      chk("rst rx_valid", 32'(bus.rx_valid), 32'd0);
      chk("rst disconnect", 32'(bus.rx_disconnect), 32'd0);
      bus.rx_d_par = 8'h3C; bus.rx_s_par = 8'h69;
      tick();
      chk("post-rst valid", 32'(bus.rx_valid), 32'd1);
      chk("post-rst word", 32'(bus.rx_word), 32'h0000_003C);

      // Randomized traffic on both directions
      for (int i = 0; i < 400; i++) begin
         bus.tx_en    = ($urandom_range(0, 7) != 0);
         bus.tx_valid = $urandom_range(0, 1);
         bus.tx_word  = 8'($urandom);
         bus.rx_align = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) begin
            bus.rx_d_par = {W{bus.rx_d_par[W-1]}};
            bus.rx_s_par = {W{bus.rx_s_par[W-1]}};
         end else begin
            bus.rx_d_par = 8'($urandom);
            bus.rx_s_par = 8'($urandom);
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
